// File: rtl/bus_control_logic.sv
// Host-bus front end of the 8259-compatible PIC: latches CPU writes
// and decodes each completed write into a one-cycle command strobe.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   chip_select_n           CS#, active low
//   read_enable_n           RD#, active low
//   write_enable_n          WR#, active low
//   data_bus_in[7:0]        CPU write data
//   A0                      register address bit
//   internal_data_bus[7:0]  latched write data
//   write_*                 one-cycle command strobes (ICW1, ICW2-4,
//                           OCW1, OCW2, OCW3)
//   read                    read cycle active (combinational)
module bus_control_logic (
    input  logic       clock,
    input  logic       reset,
    input  logic       chip_select_n,
    input  logic       read_enable_n,
    input  logic       write_enable_n,
    input  logic [7:0] data_bus_in,
    input  logic       A0,
    output logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1_reset,
    output logic       write_initial_command_word_2_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       read
);

    logic [7:0] r_data;
    logic       r_stable_a0;
    logic       r_prev_wr;
    logic       w_write_flag;
    logic       w_wr_active;

    assign w_wr_active = ~chip_select_n & ~write_enable_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data      <= 8'h00;
            r_stable_a0 <= 1'b0;
            r_prev_wr   <= 1'b1;
        end else begin
            if (w_wr_active) begin
                r_data      <= data_bus_in;
                r_stable_a0 <= A0;
            end
            // CS# high forces "not writing" so WR# toggles without
            // chip select never arm a strobe.
            r_prev_wr <= chip_select_n ? 1'b1 : write_enable_n;
        end
    end

    // WR# alone ends the write, so CS# rising with WR# still counts.
    assign w_write_flag = ~r_prev_wr & write_enable_n & ~reset;

    always_comb begin
        write_initial_command_word_1_reset = 1'b0;
        write_initial_command_word_2_4     = 1'b0;
        write_operation_control_word_1     = 1'b0;
        write_operation_control_word_2     = 1'b0;
        write_operation_control_word_3     = 1'b0;
        if (w_write_flag) begin
            write_initial_command_word_1_reset =
                ~r_stable_a0 & r_data[4];
            write_initial_command_word_2_4 = r_stable_a0;
            write_operation_control_word_1 = r_stable_a0;
            write_operation_control_word_2 =
                ~r_stable_a0 & ~r_data[4] & ~r_data[3];
            write_operation_control_word_3 =
                ~r_stable_a0 & ~r_data[4] & r_data[3];
        end
    end

    assign internal_data_bus = r_data;
    assign read              = ~chip_select_n & ~read_enable_n;

endmodule

// File: tb/tb_bus_control_logic.sv
// Self-checking bench for bus_control_logic: directed test-plan cases
// with literal expectations plus randomized bus traffic vs. a model.
module tb_bus_control_logic;

    logic       clock = 1'b0;
    logic       reset;
    logic       cs_n, rd_n, wr_n, a0;
    logic [7:0] din;
    logic [7:0] bus;
    logic       icw1, icw24, ocw1, ocw2, ocw3, rd;

    int n_cmp = 0;
    int n_bad = 0;

    bus_control_logic dut (
        .clock                              (clock),
        .reset                              (reset),
        .chip_select_n                      (cs_n),
        .read_enable_n                      (rd_n),
        .write_enable_n                     (wr_n),
        .data_bus_in                        (din),
        .A0                                 (a0),
        .internal_data_bus                  (bus),
        .write_initial_command_word_1_reset (icw1),
        .write_initial_command_word_2_4     (icw24),
        .write_operation_control_word_1     (ocw1),
        .write_operation_control_word_2     (ocw2),
        .write_operation_control_word_3     (ocw3),
        .read                               (rd)
    );

    always #5 clock = ~clock;

    // Model: the last data/address captured, and whether a CPU write
    // (CS# and WR# both low at the last edge) is still in progress.
    logic [7:0] m_bus;
    logic       m_a0;
    logic       m_in_write;
    logic       m_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_bus      = 8'h00;
            m_a0       = 1'b0;
            m_in_write = 1'b0;
            m_valid    = 1'b1;
        end else begin
            m_in_write = (!cs_n && !wr_n);
            if (m_in_write) begin
                m_bus = din;
                m_a0  = a0;
            end
        end
    end

    // Strobe vector order: {ICW1, ICW2_4, OCW1, OCW2, OCW3}.
    function automatic logic [4:0] classify(input logic adr,
                                            input logic [7:0] d);
        if (adr)       return 5'b01100;
        else if (d[4]) return 5'b10000;
        else if (d[3]) return 5'b00001;
        else           return 5'b00010;
    endfunction

    function automatic logic [4:0] model_strobes();
        if (m_in_write && wr_n && !reset) return classify(m_a0, m_bus);
        return 5'b00000;
    endfunction

    wire [4:0] strb = {icw1, icw24, ocw1, ocw2, ocw3};

    always @(negedge clock) begin
        if (m_valid) begin
            n_cmp++;
            if (bus !== m_bus) begin
                n_bad++;
                $display("FAIL model_bus: got %h want %h", bus, m_bus);
            end
            n_cmp++;
            if (strb !== model_strobes()) begin
                n_bad++;
                $display("FAIL model_strobes: got %b want %b",
                         strb, model_strobes());
            end
            n_cmp++;
            if (rd !== (!cs_n && !rd_n)) begin
                n_bad++;
                $display("FAIL model_read: got %b want %b",
                         rd, (!cs_n && !rd_n));
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic c, input logic r, input logic w,
                         input logic a, input logic [7:0] d);
        cs_n = c; rd_n = r; wr_n = w; a0 = a; din = d;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic do_write(input string name, input logic a,
                            input logic [7:0] d, input logic [4:0] exp);
        drive(1'b0, 1'b1, 1'b0, a, d);
        step();
        drive(1'b1, 1'b1, 1'b1, a, 8'h5A);
        sample();
        chk({name, "_bus"}, bus, d);
        chk({name, "_pulse"}, {3'b000, strb}, {3'b000, exp});
        step();
        sample();
        chk({name, "_after"}, {3'b000, strb}, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        step();
        step();
        sample();
        chk("reset_bus", bus, 8'h00);
        chk("reset_strobes", {3'b000, strb}, 8'h00);
        step();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        sample();
        chk("post_reset_strobes", {3'b000, strb}, 8'h00);

        step();
        do_write("icw1", 1'b0, 8'h10, 5'b10000);
        do_write("a0w", 1'b1, 8'h00, 5'b01100);
        do_write("ocw2", 1'b0, 8'h00, 5'b00010);
        do_write("ocw3", 1'b0, 8'h08, 5'b00001);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        sample();
        chk("read_on", {7'd0, rd}, 8'h01);
        chk("read_bus", bus, 8'h08);
        chk("read_strobes", {3'b000, strb}, 8'h00);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
        sample();
        chk("read_off", {7'd0, rd}, 8'h00);
        chk("read_bus2", bus, 8'h08);

        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h10);
        sample();
        chk("nocs_bus", bus, 8'h08);
        chk("nocs_strobes", {3'b000, strb}, 8'h00);

        // CS# rising together with WR# still completes the write.
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h18);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        sample();
        chk("csrise_icw1", {3'b000, strb}, 8'h10);

        step();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) != 0,
                  8'($urandom));
            step();
        end
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
